// File: rtl/obs_tick_pkg.sv
// Shared constants, types and LFSR helpers for the obstacle tick generator.
// Optional build macro: OBS_TICK_LFSR_STEP_EN (see obs_tick_gen.sv).
package obs_tick_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned FRAME_HZ                = 60;
    localparam int unsigned DEFAULT_FRAMES_PER_STEP = 15;
    // Rounded up so the frame rate never exceeds FRAME_HZ.
    localparam int unsigned DEFAULT_DELAY_CYCLES    =
        (CLK_HZ + FRAME_HZ - 1) / FRAME_HZ;

    localparam int unsigned LFSR_W      = 5;
    localparam int unsigned LFSR_TAP_HI = 4;
    localparam int unsigned LFSR_TAP_LO = 2;

    typedef logic [LFSR_W-1:0] rand_t;

    function automatic rand_t fix_seed(input rand_t s);
        return (s == '0) ? rand_t'(1) : s;
    endfunction

    function automatic rand_t lfsr_next(input rand_t s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/obs_lfsr5.sv
// 5-bit Fibonacci LFSR (x^5+x^3+1) with seed load on reset and advance enable.
// The all-zero lock-up state is excluded by coercing the seed.
module obs_lfsr5
    import obs_tick_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    rand_t r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= fix_seed(seed);
        end else if (advance) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/obs_tick_gen.sv
// Frame/step tick generator and placement LFSR for the obstacle datapath.
// Define OBS_TICK_LFSR_STEP_EN to advance the LFSR only on step ticks.
module obs_tick_gen
    import obs_tick_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES    = DEFAULT_DELAY_CYCLES,
    parameter int unsigned FRAMES_PER_STEP = DEFAULT_FRAMES_PER_STEP,
    parameter logic [4:0]  LFSR_SEED       = 5'h01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       frame_tick,
    output logic       step_tick,
    output logic [4:0] rand_num
);

    localparam int unsigned DW =
        (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int unsigned FW =
        (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [DW-1:0] D_RELOAD = DW'(DELAY_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(FRAMES_PER_STEP - 1);

    logic [DW-1:0] r_dcount;
    logic [FW-1:0] r_fcount;
    logic          r_frame;
    logic          r_step;
    logic          w_advance;
    rand_t         w_seed;
    rand_t         w_q;

    // Delay counter pauses (without restarting) while enable is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dcount <= D_RELOAD;
            r_frame  <= 1'b0;
        end else if (enable) begin
            if (r_dcount == '0) begin
                r_dcount <= D_RELOAD;
                r_frame  <= 1'b1;
            end else begin
                r_dcount <= r_dcount - 1'b1;
                r_frame  <= 1'b0;
            end
        end else begin
            r_frame <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fcount <= '0;
            r_step   <= 1'b0;
        end else if (r_frame) begin
            if (r_fcount == F_LAST) begin
                r_fcount <= '0;
                r_step   <= 1'b1;
            end else begin
                r_fcount <= r_fcount + 1'b1;
                r_step   <= 1'b0;
            end
        end else begin
            r_step <= 1'b0;
        end
    end

`ifdef OBS_TICK_LFSR_STEP_EN
    assign w_advance = r_step;
`else
    assign w_advance = 1'b1;
`endif

    assign w_seed = rand_t'(LFSR_SEED);

    obs_lfsr5 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (w_advance),
        .seed    (w_seed),
        .q       (w_q)
    );

    assign frame_tick = r_frame;
    assign step_tick  = r_step;
    assign rand_num   = w_q;

endmodule

// File: tb/tb_obs_tick_gen.sv
// Directed testbench for obs_tick_gen: tick timing, enable gating,
// mid-count reset, LFSR sequence, seed coercion and degenerate dividers.
module tb_obs_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rst2;
    logic       en2;
    logic       a_frame, a_step;
    logic [4:0] a_rand;
    logic       b_frame, b_step;
    logic [4:0] b_rand;
    logic       c_frame, c_step;
    logic [4:0] c_rand;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    obs_tick_gen #(
        .DELAY_CYCLES(4), .FRAMES_PER_STEP(3), .LFSR_SEED(5'h01)
    ) dut_a (
        .clock(clk), .reset(rst), .enable(en),
        .frame_tick(a_frame), .step_tick(a_step), .rand_num(a_rand)
    );

    obs_tick_gen #(
        .DELAY_CYCLES(4), .FRAMES_PER_STEP(3), .LFSR_SEED(5'h00)
    ) dut_b (
        .clock(clk), .reset(rst2), .enable(en2),
        .frame_tick(b_frame), .step_tick(b_step), .rand_num(b_rand)
    );

    obs_tick_gen #(
        .DELAY_CYCLES(1), .FRAMES_PER_STEP(1), .LFSR_SEED(5'h01)
    ) dut_c (
        .clock(clk), .reset(rst2), .enable(en2),
        .frame_tick(c_frame), .step_tick(c_step), .rand_num(c_rand)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Hand-derived LFSR value at cycle c after reset release, seed 01.
    function automatic logic [4:0] exp_rand(input int c);
`ifdef OBS_TICK_LFSR_STEP_EN
        if (c < 14) return 5'h01;
        if (c < 26) return 5'h02;
        return 5'h04;
`else
        case (c)
            0:  return 5'h01;
            1:  return 5'h02;
            2:  return 5'h04;
            3:  return 5'h09;
            4:  return 5'h12;
            5:  return 5'h05;
            31: return 5'h01;
            default: return 5'h00;
        endcase
`endif
    endfunction

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        rst2 = 1'b1;
        en2  = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_frame", 8'(a_frame), 8'h0);
        chk("rst_step", 8'(a_step), 8'h0);
        chk("rst_rand", 8'(a_rand), 8'h01);

        // Continuous enable: frames every 4, steps at 13 and 25
        rst = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            tick();
            chk($sformatf("t1_frame_c%0d", c), 8'(a_frame),
                8'((c % 4) == 0));
            chk($sformatf("t1_step_c%0d", c), 8'(a_step),
                8'(c == 13 || c == 25));
            chk($sformatf("t1_nz_c%0d", c), 8'(a_rand != 5'h00), 8'h1);
`ifdef OBS_TICK_LFSR_STEP_EN
            chk($sformatf("t4_rand_c%0d", c), 8'(a_rand), 8'(exp_rand(c)));
`else
            if (c <= 5 || c == 31)
                chk($sformatf("t4_rand_c%0d", c), 8'(a_rand),
                    8'(exp_rand(c)));
`endif
        end

        // Reset in the cycle after frame #2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("t3a_frame_c%0d", c), 8'(a_frame),
                8'((c % 4) == 0));
        end
        rst = 1'b1;
        tick();
        chk("t3_rst_frame", 8'(a_frame), 8'h0);
        chk("t3_rst_step", 8'(a_step), 8'h0);
        chk("t3_rst_rand", 8'(a_rand), 8'h01);
        rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk($sformatf("t3_frame_c%0d", c), 8'(a_frame),
                8'((c % 4) == 0));
            chk($sformatf("t3_step_c%0d", c), 8'(a_step), 8'(c == 13));
        end

        // Enable gap: 2 on, 5 off, then frame on cycle 9
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            en = !(c >= 3 && c <= 7);
            tick();
            chk($sformatf("t2_frame_c%0d", c), 8'(a_frame), 8'(c == 9));
        end
        en = 1'b1;

        // Seed 0 coerced; DELAY=1/FPS=1 degenerate dividers
        tick();
        chk("t5_seed0_rand", 8'(b_rand), 8'h01);
        chk("t6_rst_frame", 8'(c_frame), 8'h0);
        chk("t6_rst_step", 8'(c_step), 8'h0);
        rst2 = 1'b0;
        tick();
        chk("t6_frame_c1", 8'(c_frame), 8'h1);
        chk("t6_step_c1", 8'(c_step), 8'h0);
`ifdef OBS_TICK_LFSR_STEP_EN
        chk("t5_seed0_c1", 8'(b_rand), 8'h01);
`else
        chk("t5_seed0_c1", 8'(b_rand), 8'h02);
`endif
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk($sformatf("t6_frame_c%0d", c), 8'(c_frame), 8'h1);
            chk($sformatf("t6_step_c%0d", c), 8'(c_step), 8'h1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
